// File: rtl/hall_pulse_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// hall_pulse_conditioner_pkg: Hall conditioner defaults shared with dcmctrl.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hall_pulse_conditioner_pkg;

  localparam int HALL_FILTER_DEFAULT   = 48;
  localparam int HALL_PRESCALE_DEFAULT = 8;
  localparam int HALL_PERIOD_W         = 16;
  localparam int HALL_N_CHANNELS       = 6;

  // Counter must hold 0..FILTER_CYCLES-1 and stay >= 1 bit wide.
  function automatic int hall_fcnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hall_pulse_conditioner_if.sv
// ---------------------------------------------------------------------------
// hall_pulse_conditioner_if: raw Hall lines in, conditioned pulses/periods out.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hall_pulse_conditioner_if #(
  parameter int N_CHANNELS = hall_pulse_conditioner_pkg::HALL_N_CHANNELS,
  parameter int PERIOD_W   = hall_pulse_conditioner_pkg::HALL_PERIOD_W
);

  logic [N_CHANNELS-1:0]          hall_in;
  logic [N_CHANNELS-1:0]          pulse_out;
  logic [N_CHANNELS-1:0]          edge_strobe;
  logic [N_CHANNELS*PERIOD_W-1:0] period;
  logic [N_CHANNELS-1:0]          period_valid;
  logic [N_CHANNELS-1:0]          stall;

  modport master (
    output hall_in,
    input  pulse_out, edge_strobe, period, period_valid, stall
  );

  modport slave (
    input  hall_in,
    output pulse_out, edge_strobe, period, period_valid, stall
  );

endinterface

`default_nettype wire

// File: rtl/hall_pulse_conditioner_chan_filter.sv
// ---------------------------------------------------------------------------
// hall_chan_filter: one Hall channel - sync, glitch filter, edge, period.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hall_chan_filter
  import hall_pulse_conditioner_pkg::*;
#(
  parameter int FILTER_CYCLES = HALL_FILTER_DEFAULT,
  parameter int PERIOD_W      = HALL_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                hall_in,
  output logic                pulse_out,
  output logic                edge_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stall
);

  localparam int FCNT_W = hall_fcnt_width(FILTER_CYCLES);
  localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] PCNT_MAX  = '1;

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic                pulse_q, pulse_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                edge_q, edge_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                stall_q, stall_d;
  logic                have_edge_q, have_edge_d;

  always_comb begin
    s1_d        = hall_in;
    s2_d        = s1_q;
    pulse_d     = pulse_q;
    fcnt_d      = fcnt_q;
    pcnt_d      = pcnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    have_edge_d = have_edge_q;

    if (s2_q == pulse_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_LAST) begin
      pulse_d = s2_q;
      fcnt_d  = '0;
    end else begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end

    edge_d = pulse_d & ~pulse_q;

    // The strobe cycle restarts the count; a coincident tick is already counted.
    if (edge_q) begin
      pcnt_d      = tick ? PERIOD_W'(1) : '0;
      have_edge_d = 1'b1;
      if (have_edge_q) begin
        period_d = pcnt_q;
        valid_d  = 1'b1;
      end
    end else if (tick && (pcnt_q != PCNT_MAX)) begin
      pcnt_d = pcnt_q + PERIOD_W'(1);
    end

    stall_d = (pcnt_d == PCNT_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      pulse_q     <= 1'b0;
      fcnt_q      <= '0;
      edge_q      <= 1'b0;
      pcnt_q      <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stall_q     <= 1'b0;
      have_edge_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      pulse_q     <= pulse_d;
      fcnt_q      <= fcnt_d;
      edge_q      <= edge_d;
      pcnt_q      <= pcnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      stall_q     <= stall_d;
      have_edge_q <= have_edge_d;
    end
  end

  assign pulse_out    = pulse_q;
  assign edge_strobe  = edge_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign stall        = stall_q;

endmodule

`default_nettype wire

// File: rtl/hall_pulse_conditioner.sv
// ---------------------------------------------------------------------------
// hall_pulse_conditioner: per-channel Hall conditioning plus shared prescaler.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hall_pulse_conditioner
  import hall_pulse_conditioner_pkg::*;
#(
  parameter int N_CHANNELS    = HALL_N_CHANNELS,
  parameter int FILTER_CYCLES = HALL_FILTER_DEFAULT,
  parameter int PRESCALE_EXP  = HALL_PRESCALE_DEFAULT,
  parameter int PERIOD_W      = HALL_PERIOD_W
) (
  input logic                      clk,
  input logic                      reset_n,
  hall_pulse_conditioner_if.slave  bus
);

  logic                          tick;
  logic [N_CHANNELS-1:0]          pulse_w;
  logic [N_CHANNELS-1:0]          edge_w;
  logic [N_CHANNELS*PERIOD_W-1:0] period_w;
  logic [N_CHANNELS-1:0]          valid_w;
  logic [N_CHANNELS-1:0]          stall_w;

  generate
    if (PRESCALE_EXP == 0) begin : g_tick_every_clk
      assign tick = 1'b1;
    end else begin : g_prescaler
      logic [PRESCALE_EXP-1:0] pre_q, pre_d;

      always_comb begin
        pre_d = pre_q + PRESCALE_EXP'(1);
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      assign tick = &pre_q;
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
      hall_chan_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .PERIOD_W      (PERIOD_W)
      ) u_chan (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .hall_in      (bus.hall_in[i]),
        .pulse_out    (pulse_w[i]),
        .edge_strobe  (edge_w[i]),
        .period       (period_w[i*PERIOD_W +: PERIOD_W]),
        .period_valid (valid_w[i]),
        .stall        (stall_w[i])
      );
    end
  endgenerate

  assign bus.pulse_out    = pulse_w;
  assign bus.edge_strobe  = edge_w;
  assign bus.period       = period_w;
  assign bus.period_valid = valid_w;
  assign bus.stall        = stall_w;

endmodule

`default_nettype wire
